// File: rtl/arb_pkg.sv
// Shared definitions for the AES/SHA memory-port arbiter: FSM encoding and requester IDs.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic REQ_AES = 1'b0;
  localparam logic REQ_SHA = 1'b1;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin pick: on a tie the requester that did not win last time gets the bus.
module arb_rr2
  import arb_pkg::*;
(
  input  logic       aes_req,
  input  logic       sha_req,
  input  logic       last,
  output logic [1:0] win
);

  always_comb begin
    win = 2'b00;
    if (aes_req && (!sha_req || last == REQ_SHA)) begin
      win[REQ_AES] = 1'b1;
    end else if (sha_req) begin
      win[REQ_SHA] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one external memory port between the AES and SHA FSMs, one burst at a time.
// Optional stall watchdog enabled by defining ARB_TIMEOUT_EN.
module mem_arbiter
  import arb_pkg::*;
#(
  parameter int ADDRW   = 24,
  parameter int LENW    = 8,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             aes_req,
  input  logic             aes_we,
  input  logic [ADDRW-1:0] aes_addr,
  input  logic [LENW-1:0]  aes_len,
  input  logic [7:0]       aes_wdata,
  input  logic             sha_req,
  input  logic             sha_we,
  input  logic [ADDRW-1:0] sha_addr,
  input  logic [LENW-1:0]  sha_len,
  input  logic [7:0]       sha_wdata,
  output logic             aes_gnt,
  output logic             aes_beat,
  output logic             aes_done,
  output logic             sha_gnt,
  output logic             sha_beat,
  output logic             sha_done,
  output logic [7:0]       rdata,
  output logic             err,
  output logic             mem_valid,
  output logic             mem_we,
  output logic [ADDRW-1:0] mem_addr,
  output logic [7:0]       mem_wdata,
  input  logic             mem_ready,
  input  logic [7:0]       mem_rdata
);

  state_t          state;
  logic            last;
  logic            owner;
  logic [1:0]      win;
  logic [LENW-1:0] len_r;
  logic [LENW-1:0] cnt;
  logic            accept;
  logic            start;

  arb_rr2 u_rr (
    .aes_req (aes_req),
    .sha_req (sha_req),
    .last    (last),
    .win     (win)
  );

  assign start     = (state == IDLE) && (|win);
  assign accept    = mem_valid && mem_ready;
  assign aes_beat  = aes_gnt && accept;
  assign sha_beat  = sha_gnt && accept;
  assign mem_wdata = (owner == REQ_SHA) ? sha_wdata : aes_wdata;
  assign rdata     = mem_rdata;

`ifdef ARB_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT + 1);
  logic [STALL_W-1:0] stall;
  logic               stall_hit;
  // Aborting on the TIMEOUT-th stalled cycle itself, so done lands TIMEOUT cycles into the stall.
  assign stall_hit = (stall == STALL_W'(TIMEOUT - 1));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      aes_gnt   <= 1'b0;
      sha_gnt   <= 1'b0;
      aes_done  <= 1'b0;
      sha_done  <= 1'b0;
      err       <= 1'b0;
      mem_valid <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      last      <= REQ_SHA;
      owner     <= REQ_AES;
`ifdef ARB_TIMEOUT_EN
      stall     <= '0;
`endif
    end else begin
      aes_done <= 1'b0;
      sha_done <= 1'b0;
      err      <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            owner     <= win[REQ_SHA] ? REQ_SHA : REQ_AES;
            aes_gnt   <= win[REQ_AES];
            sha_gnt   <= win[REQ_SHA];
            mem_valid <= 1'b1;
            mem_we    <= win[REQ_SHA] ? sha_we : aes_we;
            mem_addr  <= win[REQ_SHA] ? sha_addr : aes_addr;
`ifdef ARB_TIMEOUT_EN
            stall     <= '0;
`endif
            state     <= XFER;
          end
        end
        XFER: begin
          if (accept) begin
`ifdef ARB_TIMEOUT_EN
            stall <= '0;
`endif
            if (cnt == len_r) begin
              aes_gnt   <= 1'b0;
              sha_gnt   <= 1'b0;
              mem_valid <= 1'b0;
              aes_done  <= (owner == REQ_AES);
              sha_done  <= (owner == REQ_SHA);
              state     <= DONE;
            end else begin
              mem_addr <= mem_addr + ADDRW'(1);
            end
          end
`ifdef ARB_TIMEOUT_EN
          else if (stall_hit) begin
            aes_gnt   <= 1'b0;
            sha_gnt   <= 1'b0;
            mem_valid <= 1'b0;
            aes_done  <= (owner == REQ_AES);
            sha_done  <= (owner == REQ_SHA);
            err       <= 1'b1;
            state     <= DONE;
          end else begin
            stall <= stall + STALL_W'(1);
          end
`endif
        end
        DONE: begin
          last  <= owner;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Burst length and beat count are only meaningful once a grant has loaded them.
  always_ff @(posedge clk) begin
    if (start) begin
      len_r <= win[REQ_SHA] ? sha_len : aes_len;
      cnt   <= '0;
    end else if (state == XFER && accept) begin
      cnt <= cnt + LENW'(1);
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; adds a watchdog case when ARB_TIMEOUT_EN is defined.
module tb_mem_arbiter;

  localparam int ADDRW = 24;
  localparam int LENW  = 8;
`ifdef ARB_TIMEOUT_EN
  localparam int TMO     = 4;
  localparam int STALL_N = 3;
`else
  localparam int TMO     = 255;
  localparam int STALL_N = 10;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             aes_req, aes_we, sha_req, sha_we;
  logic [ADDRW-1:0] aes_addr, sha_addr;
  logic [LENW-1:0]  aes_len, sha_len;
  logic [7:0]       aes_wdata, sha_wdata;
  logic             aes_gnt, aes_beat, aes_done, sha_gnt, sha_beat, sha_done;
  logic [7:0]       rdata;
  logic             err;
  logic             mem_valid, mem_we, mem_ready;
  logic [ADDRW-1:0] mem_addr;
  logic [7:0]       mem_wdata, mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  mem_arbiter #(.ADDRW(ADDRW), .LENW(LENW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .aes_req(aes_req), .aes_we(aes_we), .aes_addr(aes_addr), .aes_len(aes_len),
    .aes_wdata(aes_wdata),
    .sha_req(sha_req), .sha_we(sha_we), .sha_addr(sha_addr), .sha_len(sha_len),
    .sha_wdata(sha_wdata),
    .aes_gnt(aes_gnt), .aes_beat(aes_beat), .aes_done(aes_done),
    .sha_gnt(sha_gnt), .sha_beat(sha_beat), .sha_done(sha_done),
    .rdata(rdata), .err(err),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [ADDRW-1:0] wrap_exp [3];

  initial begin
    wrap_exp[0] = 24'hFFFFFE;
    wrap_exp[1] = 24'hFFFFFF;
    wrap_exp[2] = 24'h000000;

    rst_n = 1'b0;
    aes_req = 1'b0; aes_we = 1'b0; aes_addr = '0; aes_len = '0; aes_wdata = '0;
    sha_req = 1'b0; sha_we = 1'b0; sha_addr = '0; sha_len = '0; sha_wdata = '0;
    mem_ready = 1'b1; mem_rdata = '0;
    #1;
    check("rst_aes_gnt", aes_gnt, 0);
    check("rst_sha_gnt", sha_gnt, 0);
    check("rst_done", {aes_done, sha_done}, 0);
    check("rst_err", err, 0);
    check("rst_mem_valid", mem_valid, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);

    // Both requesting from reset, single-beat bursts: AES first, then alternate.
    aes_req = 1'b1; aes_addr = 24'h000010;
    sha_req = 1'b1; sha_addr = 24'h000020;
    tick();
    rst_n = 1'b1;
    tick();
    for (int c = 0; c < 12; c++) begin
      check($sformatf("rr_aes_gnt_c%0d", c), aes_gnt, (c % 6 == 0));
      check($sformatf("rr_sha_gnt_c%0d", c), sha_gnt, (c % 6 == 3));
      check($sformatf("rr_aes_done_c%0d", c), aes_done, (c % 6 == 1));
      check($sformatf("rr_sha_done_c%0d", c), sha_done, (c % 6 == 4));
      if (c % 6 == 0) check("rr_aes_addr", mem_addr, 24'h000010);
      if (c % 6 == 3) check("rr_sha_addr", mem_addr, 24'h000020);
      if (c == 11) begin
        aes_req = 1'b0;
        sha_req = 1'b0;
      end
      tick();
    end
    check("rr_idle_after_drop", {aes_gnt, sha_gnt}, 0);

    // AES read, 4 beats, zero-wait memory.
    aes_addr = 24'h000100; aes_len = 8'd3; aes_we = 1'b0; aes_req = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      mem_rdata = 8'h50 + 8'(i);
      #1;
      check($sformatf("rd_addr_%0d", i), mem_addr, 24'h000100 + i);
      check($sformatf("rd_beat_%0d", i), aes_beat, 1);
      check($sformatf("rd_valid_%0d", i), mem_valid, 1);
      check($sformatf("rd_we_%0d", i), mem_we, 0);
      check($sformatf("rd_sha_gnt_%0d", i), sha_gnt, 0);
      check($sformatf("rd_rdata_%0d", i), rdata, 8'h50 + i);
      tick();
    end
    check("rd_done", aes_done, 1);
    check("rd_gnt_drop", aes_gnt, 0);
    check("rd_valid_drop", mem_valid, 0);
    check("rd_beat_after", aes_beat, 0);
    check("rd_err", err, 0);
    aes_req = 1'b0;
    tick();
    check("rd_done_pulse", aes_done, 0);

    // SHA write across the top of the address space; request fields change mid-burst.
    sha_addr = 24'hFFFFFE; sha_len = 8'd2; sha_we = 1'b1; sha_req = 1'b1;
    tick();
    sha_addr = 24'h123456; sha_len = 8'd0; sha_we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sha_wdata = 8'hA0 + 8'(i);
      #1;
      check($sformatf("wr_addr_%0d", i), mem_addr, wrap_exp[i]);
      check($sformatf("wr_we_%0d", i), mem_we, 1);
      check($sformatf("wr_wdata_%0d", i), mem_wdata, 8'hA0 + i);
      check($sformatf("wr_beat_%0d", i), sha_beat, 1);
      check($sformatf("wr_aes_gnt_%0d", i), aes_gnt, 0);
      tick();
    end
    check("wr_done", sha_done, 1);
    check("wr_aes_done", aes_done, 0);
    sha_req = 1'b0;
    tick();

    // Memory stalls mid-burst; requester drops req during the stall.
    aes_addr = 24'h002000; aes_len = 8'd2; aes_req = 1'b1; mem_ready = 1'b1;
    tick();
    check("st_beat0_addr", mem_addr, 24'h002000);
    check("st_beat0", aes_beat, 1);
    tick();
    mem_ready = 1'b0;
    aes_req = 1'b0;
    #1;
    for (int s = 0; s < STALL_N; s++) begin
      check($sformatf("st_valid_%0d", s), mem_valid, 1);
      check($sformatf("st_addr_%0d", s), mem_addr, 24'h002001);
      check($sformatf("st_nobeat_%0d", s), aes_beat, 0);
      check($sformatf("st_nodone_%0d", s), aes_done, 0);
      tick();
    end
    mem_ready = 1'b1;
    #1;
    check("st_resume_addr", mem_addr, 24'h002001);
    check("st_resume_beat", aes_beat, 1);
    tick();
    check("st_last_addr", mem_addr, 24'h002002);
    check("st_last_beat", aes_beat, 1);
    tick();
    check("st_done", aes_done, 1);
    check("st_err", err, 0);
    tick();

`ifdef ARB_TIMEOUT_EN
    // Memory never answers: watchdog aborts after TMO stalled cycles.
    aes_addr = 24'h000040; aes_len = 8'd3; aes_req = 1'b1; mem_ready = 1'b0;
    tick();
    for (int c = 0; c < TMO; c++) begin
      check($sformatf("to_gnt_%0d", c), aes_gnt, 1);
      check($sformatf("to_nodone_%0d", c), aes_done, 0);
      check($sformatf("to_noerr_%0d", c), err, 0);
      tick();
    end
    check("to_done", aes_done, 1);
    check("to_err", err, 1);
    check("to_valid_drop", mem_valid, 0);
    aes_req = 1'b0;
    tick();
    check("to_err_pulse", err, 0);
    check("to_done_pulse", aes_done, 0);
    mem_ready = 1'b1;
    tick();
`endif

    // Reset during beat 2 of 5; a tie afterwards must go to AES.
    aes_addr = 24'h000300; aes_len = 8'd4; aes_we = 1'b0; aes_req = 1'b1;
    sha_addr = 24'h000400; sha_len = 8'd0; mem_ready = 1'b1;
    tick();
    tick();
    tick();
    check("rm_beat2_addr", mem_addr, 24'h000302);
    sha_req = 1'b1;
    rst_n = 1'b0;
    #1;
    check("rm_gnt", {aes_gnt, sha_gnt}, 0);
    check("rm_valid", mem_valid, 0);
    check("rm_addr", mem_addr, 0);
    check("rm_beat", aes_beat, 0);
    check("rm_done", aes_done, 0);
    aes_addr = 24'h000500;
    tick();
    check("rm_done_held", {aes_done, sha_done}, 0);
    rst_n = 1'b1;
    tick();
    check("rm_regrant_aes", aes_gnt, 1);
    check("rm_regrant_sha", sha_gnt, 0);
    check("rm_regrant_addr", mem_addr, 24'h000500);
    aes_req = 1'b0;
    sha_req = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the single external memory port between the AES FSM and the SHA FSM. Each FSM issues a burst request (base address, beat count, direction); the arbiter grants one at a time with round-robin fairness, generates sequential byte addresses, forwards data beats and signals completion. It sits between the per-engine FSMs, which are fed by the request queue, and the memory/SPI master.

## Interface
Parameters:
- ADDRW, 24, byte address width
- LENW, 8, burst length field width; beats = len + 1
- TIMEOUT, 255, stall cycles before abort (only with ARB_TIMEOUT_EN)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- aes_req / sha_req  in  1  burst request, held high until done
- aes_we / sha_we  in  1  1 = write burst, 0 = read burst
- aes_addr / sha_addr  in  ADDRW  burst base address
- aes_len / sha_len  in  LENW  beats minus one
- aes_wdata / sha_wdata  in  8  write byte for the current beat
- aes_gnt / sha_gnt  out  1  requester owns the bus
- aes_beat / sha_beat  out  1  current beat accepted; advance wdata / capture rdata
- aes_done / sha_done  out  1  one-cycle burst-complete pulse
- rdata  out  8  mem_rdata passthrough, shared by both requesters
- err  out  1  one-cycle pulse coincident with done on abort
- mem_valid  out  1  beat request to memory
- mem_we  out  1  beat direction
- mem_addr  out  ADDRW  beat address
- mem_wdata  out  8  granted requester's wdata
- mem_ready  in  1  memory accepts/completes beat
- mem_rdata  in  8  read byte, valid when mem_valid && mem_ready

## Operation
- States: IDLE, XFER, DONE.
- IDLE: if exactly one request is high, that requester wins. If both are high, the requester not granted last time wins. On a win: latch we, addr and len into working registers; clear beat_cnt and the stall counter; set gnt; go to XFER.
- XFER: mem_valid = 1, mem_addr = base + beat_cnt (modulo 2^ADDRW, wraps silently), mem_we = latched we.
- XFER, on mem_valid && mem_ready: x_beat = 1 and beat_cnt increments. If beat_cnt == latched len, go to DONE.
- DONE: gnt drops, x_done pulses, the last-grant pointer updates, and the state returns to IDLE.
- mem_wdata and rdata are combinational muxes. x_beat = x_gnt && mem_valid && mem_ready. All other outputs are registered.
- Request inputs are sampled only in IDLE. Changes to addr, len or we while granted are ignored. Dropping req mid-burst does not abort the burst.
- A requester that holds req high after done competes again. Round robin guarantees that the other requester, if pending, wins next.

## Timing
- Reset values: gnt = 0, done = 0, err = 0, mem_valid = 0, mem_we = 0, mem_addr = 0. Last-grant pointer = SHA, so AES wins the first tie.
- Reset mid-burst aborts immediately. No done pulse is issued.
- Latency: req high at cycle N in IDLE → gnt and mem_valid high at N+1.
- Zero-wait memory: a burst of len + 1 beats occupies exactly len + 1 XFER cycles.
- Last beat accepted at cycle L → done at L+1 → IDLE at L+2 → next grant at L+3. This gives 2 idle bus cycles between back-to-back bursts.
- mem_valid is never deasserted while in XFER, including while waiting on mem_ready.

## Configuration
- ARB_TIMEOUT_EN defined:
  - A stall counter increments each XFER cycle with mem_valid && !mem_ready and clears on every accepted beat.
  - When it reaches TIMEOUT, the arbiter goes to DONE with x_done = 1 and err = 1. Remaining beats are dropped.
- ARB_TIMEOUT_EN undefined: no counter; the arbiter waits on mem_ready indefinitely. err is tied to 0.

## Structure
- Shared package arb_pkg holds the state encoding (IDLE/XFER/DONE) and the requester IDs (REQ_AES = 0, REQ_SHA = 1).
- One sub-module, arb_rr2: the 2-way round-robin pick. Inputs: two requests and the last-grant bit. Outputs: one-hot winner. Purely combinational.

## Test plan
- AES only, addr 0x000100, len 3, read, mem_ready always 1: mem_addr 0x100..0x103 on 4 consecutive cycles, 4 aes_beat pulses, aes_done one cycle after the last beat, sha_gnt never set.
- Both requesters high from reset, len 0 each, held high: grants alternate AES, SHA, AES, SHA, with 2 idle cycles between bursts.
- SHA write, addr 0xFFFFFE, len 2: mem_addr sequence FFFFFE, FFFFFF, 000000 with mem_we = 1; mem_wdata tracks sha_wdata per beat.
- mem_ready low for 10 cycles mid-burst: mem_valid and mem_addr hold steady, no beat pulses, the burst resumes and completes normally.
- ARB_TIMEOUT_EN with TIMEOUT = 4, mem_ready stuck low: done and err pulse together 4 cycles into the stall, and the arbiter returns to IDLE.
- rst_n asserted during beat 2 of 5: all outputs go to 0 immediately with no done pulse; after release, a pending AES request is granted first.
